// File: rtl/knn_dist_streamer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : knn_dist_streamer_pkg
// Description : Shared constants for the k-NN distance streamer: FSM state
//               encoding, distance output width and the default coordinate
//               width used by the streamer and its distance calculator.
// Revision    : 1.0 - initial release
// ============================================================================
package knn_dist_streamer_pkg;

    // Width of the distance word handed to the downstream sorter.
    localparam int DIST_W = 32;

    // Default width of one unsigned coordinate.
    localparam int c_COORD_W_DEFAULT = 8;

    // Streamer FSM encoding.
    localparam int                   c_STATE_W   = 2;
    localparam logic [c_STATE_W-1:0] c_ST_IDLE   = 2'd0;
    localparam logic [c_STATE_W-1:0] c_ST_STREAM = 2'd1;
    localparam logic [c_STATE_W-1:0] c_ST_DONE   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/knn_dist_streamer_dist_calc.sv
`default_nettype none
// ============================================================================
// Module      : dist_calc
// Description : Purely combinational squared Euclidean distance between two
//               unsigned 2-D points, kept at full precision (no saturation).
// Ports       : DATA_X1/DATA_Y1 - first point  (COORD_W each)
//               DATA_X2/DATA_Y2 - second point (COORD_W each)
//               DATA_OUT        - dx*dx + dy*dy (2*COORD_W+1 bits)
// Revision    : 1.0 - initial release
// ============================================================================
module dist_calc
    import knn_dist_streamer_pkg::*;
#(
    parameter int COORD_W = c_COORD_W_DEFAULT
) (
    input  logic [COORD_W-1:0] DATA_X1,
    input  logic [COORD_W-1:0] DATA_Y1,
    input  logic [COORD_W-1:0] DATA_X2,
    input  logic [COORD_W-1:0] DATA_Y2,
    output logic [2*COORD_W:0] DATA_OUT
);

    logic [COORD_W-1:0]   w_dx;
    logic [COORD_W-1:0]   w_dy;
    logic [2*COORD_W-1:0] w_dx_sq;
    logic [2*COORD_W-1:0] w_dy_sq;

    always_comb begin
        // Absolute differences fit in COORD_W bits because both inputs are unsigned.
        w_dx     = (DATA_X1 >= DATA_X2) ? (DATA_X1 - DATA_X2) : (DATA_X2 - DATA_X1);
        w_dy     = (DATA_Y1 >= DATA_Y2) ? (DATA_Y1 - DATA_Y2) : (DATA_Y2 - DATA_Y1);
        w_dx_sq  = (2*COORD_W)'(w_dx) * (2*COORD_W)'(w_dx);
        w_dy_sq  = (2*COORD_W)'(w_dy) * (2*COORD_W)'(w_dy);
        // One extra bit absorbs the carry of the sum.
        DATA_OUT = {1'b0, w_dx_sq} + {1'b0, w_dy_sq};
    end

endmodule
`default_nettype wire

// File: rtl/knn_dist_streamer.sv
`default_nettype none
// ============================================================================
// Module      : knn_dist_streamer
// Description : Holds up to N_PTS training points and, on start, streams the
//               squared distance from a latched query point to every stored
//               point, one ready strobe every GAP cycles, for a downstream
//               sorter.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               load, load_x/load_y - append a training point (IDLE only)
//               clear               - empty the buffer (IDLE only, beats load)
//               test_x/test_y       - query point, latched when start accepted
//               start               - request one pass over stored points
//               busy, done, full    - pass active / end-of-pass pulse / buffer full
//               ready, DATA_OUT,    - distance strobe, distance, point index
//               IDX_OUT
// Revision    : 1.0 - initial release
// ============================================================================
module knn_dist_streamer
    import knn_dist_streamer_pkg::*;
#(
    parameter int  N_PTS   = 16,
    parameter int  COORD_W = c_COORD_W_DEFAULT,
    parameter int  GAP     = 1,
    localparam int IDX_W   = (N_PTS > 1) ? $clog2(N_PTS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [COORD_W-1:0] load_x,
    input  logic [COORD_W-1:0] load_y,
    input  logic               clear,
    input  logic [COORD_W-1:0] test_x,
    input  logic [COORD_W-1:0] test_y,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               full,
    output logic               ready,
    output logic [DIST_W-1:0]  DATA_OUT,
    output logic [IDX_W-1:0]   IDX_OUT
);

    localparam int c_CNT_W  = $clog2(N_PTS + 1);
    localparam int c_GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int c_CALC_W = 2*COORD_W + 1;

    // ------------------------------------------------------------------
    // State and storage
    // ------------------------------------------------------------------
    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_nxt;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_CNT_W-1:0]   r_idx;       // index of the next point to strobe
    logic [c_GAP_W-1:0]   r_gap;       // cycles left before the next strobe
    logic [COORD_W-1:0]   r_tx;
    logic [COORD_W-1:0]   r_ty;
    logic [COORD_W-1:0]   r_mem_x [N_PTS];
    logic [COORD_W-1:0]   r_mem_y [N_PTS];
    logic                 r_ready;
    logic [DIST_W-1:0]    r_data;
    logic [IDX_W-1:0]     r_idx_out;

    logic                 w_idle;
    logic                 w_accept;
    logic                 w_all_issued;
    logic                 w_issue;
    logic                 w_cfg_ok;
    logic                 w_load_ok;
    logic                 w_clear_ok;
    logic [IDX_W-1:0]     w_rd_idx;
    logic [IDX_W-1:0]     w_wr_idx;
    logic [COORD_W-1:0]   w_qx;
    logic [COORD_W-1:0]   w_qy;
    logic [c_CALC_W-1:0]  w_dist;
    logic [DIST_W-1:0]    w_dist_ext;

    // ------------------------------------------------------------------
    // Control decodes
    // ------------------------------------------------------------------
    always_comb begin
        w_idle       = (r_state == c_ST_IDLE);
        w_accept     = w_idle && start && (r_count != '0);
        w_all_issued = (r_idx == r_count);
        w_issue      = (r_state == c_ST_STREAM) && !w_all_issued && (r_gap == '0);
        // Buffer edits are frozen in the cycle a start is taken so the pass
        // always sees a stable point set.
        w_cfg_ok     = w_idle && !start;
        w_clear_ok   = w_cfg_ok && clear;
        w_load_ok    = w_cfg_ok && load && !clear && !full;
        w_wr_idx     = r_count[IDX_W-1:0];
    end

    // Index 0 is strobed on the accepting edge itself, so in IDLE the
    // calculator sees point 0 against the live query inputs; during the
    // pass it sees the next point against the latched query.
    always_comb begin
        w_rd_idx = w_idle ? '0     : r_idx[IDX_W-1:0];
        w_qx     = w_idle ? test_x : r_tx;
        w_qy     = w_idle ? test_y : r_ty;
    end

    dist_calc #(
        .COORD_W (COORD_W)
    ) u_dist_calc (
        .DATA_X1  (r_mem_x[w_rd_idx]),
        .DATA_Y1  (r_mem_y[w_rd_idx]),
        .DATA_X2  (w_qx),
        .DATA_Y2  (w_qy),
        .DATA_OUT (w_dist)
    );

    assign w_dist_ext = DIST_W'(w_dist);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (r_count != '0) ? c_ST_STREAM : c_ST_DONE;
                end
            end
            c_ST_STREAM: begin
                if (w_all_issued) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy     = (r_state == c_ST_STREAM);
        done     = (r_state == c_ST_DONE);
        full     = (r_count == c_CNT_W'(N_PTS));
        ready    = r_ready;
        DATA_OUT = r_data;
        IDX_OUT  = r_idx_out;
    end

    // ------------------------------------------------------------------
    // Strobe datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready   <= 1'b0;
            r_data    <= '0;
            r_idx_out <= '0;
            r_idx     <= '0;
            r_gap     <= '0;
            r_tx      <= '0;
            r_ty      <= '0;
        end else begin
            r_ready <= 1'b0;
            if (w_accept) begin
                r_tx      <= test_x;
                r_ty      <= test_y;
                r_ready   <= 1'b1;
                r_data    <= w_dist_ext;
                r_idx_out <= '0;
                r_idx     <= c_CNT_W'(1);
                r_gap     <= c_GAP_W'(GAP - 1);
            end else if (w_issue) begin
                r_ready   <= 1'b1;
                r_data    <= w_dist_ext;
                r_idx_out <= w_rd_idx;
                r_idx     <= r_idx + 1'b1;
                r_gap     <= c_GAP_W'(GAP - 1);
            end else if ((r_state == c_ST_STREAM) && (r_gap != '0)) begin
                r_gap <= r_gap - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Point buffer: count is reset, storage is not (count=0 invalidates it)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_clear_ok) begin
            r_count <= '0;
        end else if (w_load_ok) begin
            r_count <= r_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_load_ok) begin
            r_mem_x[w_wr_idx] <= load_x;
            r_mem_y[w_wr_idx] <= load_y;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_knn_dist_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_knn_dist_streamer
// Description : Self-checking bench for knn_dist_streamer. Instance A uses
//               N_PTS=16/GAP=1, instance B uses N_PTS=4/GAP=5; both share the
//               stimulus. Expected strobes are queued when a pass is started
//               and compared against the strobes the DUT produced.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_knn_dist_streamer;

    localparam int N_A   = 16;
    localparam int N_B   = 4;
    localparam int GAP_B = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic        clear;
    logic        start;
    logic [7:0]  load_x;
    logic [7:0]  load_y;
    logic [7:0]  test_x;
    logic [7:0]  test_y;

    logic        busy_a, done_a, full_a, ready_a;
    logic [31:0] data_a;
    logic [3:0]  idx_a;
    logic        busy_b, done_b, full_b, ready_b;
    logic [31:0] data_b;
    logic [1:0]  idx_b;

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboard: expected strobes (index, distance, cycle offset from start)
    int exp_idx[$];
    int exp_dist[$];
    int exp_cyc[$];
    // Observed strobes
    int obs_idx[$];
    int obs_dist[$];
    int obs_cyc[$];
    int obs_done_cyc;
    int obs_done_cnt;
    int obs_busy_cnt;

    knn_dist_streamer #(.N_PTS(N_A), .COORD_W(8), .GAP(1)) dut_a (
        .clk(clk), .rst(rst), .load(load), .load_x(load_x), .load_y(load_y),
        .clear(clear), .test_x(test_x), .test_y(test_y), .start(start),
        .busy(busy_a), .done(done_a), .full(full_a), .ready(ready_a),
        .DATA_OUT(data_a), .IDX_OUT(idx_a)
    );

    knn_dist_streamer #(.N_PTS(N_B), .COORD_W(8), .GAP(GAP_B)) dut_b (
        .clk(clk), .rst(rst), .load(load), .load_x(load_x), .load_y(load_y),
        .clear(clear), .test_x(test_x), .test_y(test_y), .start(start),
        .busy(busy_b), .done(done_b), .full(full_b), .ready(ready_b),
        .DATA_OUT(data_b), .IDX_OUT(idx_b)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int model_dist(input int x, input int y, input int tx, input int ty);
        int dx;
        int dy;
        dx = (x > tx) ? (x - tx) : (tx - x);
        dy = (y > ty) ? (y - ty) : (ty - y);
        return dx*dx + dy*dy;
    endfunction

    // ---------------- stimulus helpers (all start just after a posedge) ----
    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic load_pt(input logic [7:0] x, input logic [7:0] y);
        load = 1'b1; load_x = x; load_y = y;
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    task automatic load_basic_set();
        load_pt(8'd0, 8'd0);
        load_pt(8'd3, 8'd4);
        load_pt(8'd10, 8'd0);
        load_pt(8'd255, 8'd255);
    endtask

    task automatic push_basic_expect(input int gap);
        exp_idx.delete(); exp_dist.delete(); exp_cyc.delete();
        exp_idx.push_back(0); exp_dist.push_back(0);      exp_cyc.push_back(0);
        exp_idx.push_back(1); exp_dist.push_back(25);     exp_cyc.push_back(gap);
        exp_idx.push_back(2); exp_dist.push_back(100);    exp_cyc.push_back(2*gap);
        exp_idx.push_back(3); exp_dist.push_back(130050); exp_cyc.push_back(3*gap);
    endtask

    task automatic start_pass(input logic [7:0] tx, input logic [7:0] ty);
        test_x = tx; test_y = ty; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Records what one DUT does for 'budget' cycles after the accepting edge.
    task automatic collect(input bit sel_b, input int budget);
        obs_idx.delete(); obs_dist.delete(); obs_cyc.delete();
        obs_done_cyc = -1; obs_done_cnt = 0; obs_busy_cnt = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (sel_b ? ready_b : ready_a) begin
                obs_idx.push_back(sel_b ? int'(idx_b) : int'(idx_a));
                obs_dist.push_back(sel_b ? int'(data_b) : int'(data_a));
                obs_cyc.push_back(c);
            end
            if (sel_b ? busy_b : busy_a) obs_busy_cnt++;
            if (sel_b ? done_b : done_a) begin
                if (obs_done_cnt == 0) obs_done_cyc = c;
                obs_done_cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({ready_a, done_a, busy_a, full_a} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_flags: got rdy/done/busy/full=%b required 0000",
                     {ready_a, done_a, busy_a, full_a});
        end
        n_cmp++;
        if (data_a !== 32'd0 || idx_a !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got DATA_OUT=%0d IDX_OUT=%0d required 0/0", data_a, idx_a);
        end
        n_cmp++;
        if ({ready_b, done_b, busy_b, full_b} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_flags_b: got %b required 0000", {ready_b, done_b, busy_b, full_b});
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_basic();
        int k;
        do_reset();
        load_basic_set();
        push_basic_expect(1);
        start_pass(8'd0, 8'd0);
        collect(1'b0, 10);
        n_cmp++;
        if (obs_idx.size() != 4) begin
            n_bad++;
            $display("FAIL basic_strobe_count: got %0d required 4", obs_idx.size());
        end
        k = 0;
        while (exp_idx.size() > 0 && obs_idx.size() > 0) begin
            int ei, ed, ec, oi, od, oc;
            ei = exp_idx.pop_front(); ed = exp_dist.pop_front(); ec = exp_cyc.pop_front();
            oi = obs_idx.pop_front(); od = obs_dist.pop_front(); oc = obs_cyc.pop_front();
            n_cmp++;
            if (oi !== ei || od !== ed || oc !== ec) begin
                n_bad++;
                $display("FAIL basic_strobe%0d: got idx=%0d dist=%0d cyc=%0d required idx=%0d dist=%0d cyc=%0d",
                         k, oi, od, oc, ei, ed, ec);
            end
            k++;
        end
        n_cmp++;
        if (obs_done_cyc !== 4 || obs_done_cnt !== 1 || obs_busy_cnt !== 4) begin
            n_bad++;
            $display("FAIL basic_done: got done_cyc=%0d done_cnt=%0d busy_cycles=%0d required 4/1/4",
                     obs_done_cyc, obs_done_cnt, obs_busy_cnt);
        end
    endtask

    task automatic test_gap();
        int k;
        do_reset();
        load_basic_set();
        push_basic_expect(GAP_B);
        start_pass(8'd0, 8'd0);
        collect(1'b1, 22);
        n_cmp++;
        if (obs_idx.size() != 4) begin
            n_bad++;
            $display("FAIL gap_strobe_count: got %0d required 4", obs_idx.size());
        end
        k = 0;
        while (exp_idx.size() > 0 && obs_idx.size() > 0) begin
            int ei, ed, ec, oi, od, oc;
            ei = exp_idx.pop_front(); ed = exp_dist.pop_front(); ec = exp_cyc.pop_front();
            oi = obs_idx.pop_front(); od = obs_dist.pop_front(); oc = obs_cyc.pop_front();
            n_cmp++;
            if (oi !== ei || od !== ed || oc !== ec) begin
                n_bad++;
                $display("FAIL gap_strobe%0d: got idx=%0d dist=%0d cyc=%0d required idx=%0d dist=%0d cyc=%0d",
                         k, oi, od, oc, ei, ed, ec);
            end
            k++;
        end
        n_cmp++;
        if (obs_done_cyc !== 3*GAP_B + 1 || obs_done_cnt !== 1) begin
            n_bad++;
            $display("FAIL gap_done: got done_cyc=%0d done_cnt=%0d required %0d/1",
                     obs_done_cyc, obs_done_cnt, 3*GAP_B + 1);
        end
    endtask

    task automatic test_empty_and_clear();
        do_reset();
        start_pass(8'd5, 8'd5);
        collect(1'b0, 6);
        n_cmp++;
        if (obs_idx.size() != 0 || obs_done_cyc !== 0 || obs_done_cnt !== 1 || obs_busy_cnt !== 0) begin
            n_bad++;
            $display("FAIL empty_pass: got strobes=%0d done_cyc=%0d done_cnt=%0d busy=%0d required 0/0/1/0",
                     obs_idx.size(), obs_done_cyc, obs_done_cnt, obs_busy_cnt);
        end
        // Two points loaded, then load+clear together: clear must win.
        load_pt(8'd1, 8'd2);
        load_pt(8'd3, 8'd4);
        load = 1'b1; clear = 1'b1; load_x = 8'd9; load_y = 8'd9;
        @(posedge clk);
        #1 load = 1'b0; clear = 1'b0;
        start_pass(8'd0, 8'd0);
        collect(1'b0, 6);
        n_cmp++;
        if (obs_idx.size() != 0 || obs_done_cyc !== 0 || obs_busy_cnt !== 0) begin
            n_bad++;
            $display("FAIL clear_wins: got strobes=%0d done_cyc=%0d busy=%0d required 0/0/0",
                     obs_idx.size(), obs_done_cyc, obs_busy_cnt);
        end
    endtask

    task automatic test_overflow();
        int k;
        do_reset();
        exp_idx.delete(); exp_dist.delete(); exp_cyc.delete();
        for (int i = 0; i < N_A + 2; i++) begin
            load_pt(8'(i*13 + 2), 8'(250 - i*11));
            if (i < N_A) begin
                exp_idx.push_back(i);
                exp_dist.push_back(model_dist(i*13 + 2, 250 - i*11, 100, 37));
                exp_cyc.push_back(i);
            end
            if (i == N_A - 2) begin
                n_cmp++;
                if (full_a !== 1'b0) begin
                    n_bad++;
                    $display("FAIL full_early: got full=%b required 0 after %0d loads", full_a, N_A - 1);
                end
            end
            if (i == N_A - 1) begin
                n_cmp++;
                if (full_a !== 1'b1) begin
                    n_bad++;
                    $display("FAIL full_set: got full=%b required 1 after %0d loads", full_a, N_A);
                end
            end
        end
        n_cmp++;
        if (full_a !== 1'b1 || full_b !== 1'b1) begin
            n_bad++;
            $display("FAIL full_hold: got full_a=%b full_b=%b required 1/1", full_a, full_b);
        end
        start_pass(8'd100, 8'd37);
        collect(1'b0, N_A + 6);
        n_cmp++;
        if (obs_idx.size() != N_A) begin
            n_bad++;
            $display("FAIL overflow_strobe_count: got %0d required %0d", obs_idx.size(), N_A);
        end
        k = 0;
        while (exp_idx.size() > 0 && obs_idx.size() > 0) begin
            int ei, ed, ec, oi, od, oc;
            ei = exp_idx.pop_front(); ed = exp_dist.pop_front(); ec = exp_cyc.pop_front();
            oi = obs_idx.pop_front(); od = obs_dist.pop_front(); oc = obs_cyc.pop_front();
            n_cmp++;
            if (oi !== ei || od !== ed || oc !== ec) begin
                n_bad++;
                $display("FAIL overflow_strobe%0d: got idx=%0d dist=%0d cyc=%0d required idx=%0d dist=%0d cyc=%0d",
                         k, oi, od, oc, ei, ed, ec);
            end
            k++;
        end
        n_cmp++;
        if (obs_done_cyc !== N_A || obs_done_cnt !== 1) begin
            n_bad++;
            $display("FAIL overflow_done: got done_cyc=%0d done_cnt=%0d required %0d/1",
                     obs_done_cyc, obs_done_cnt, N_A);
        end
    endtask

    task automatic test_reset_mid_pass();
        int strobes;
        int stray;
        do_reset();
        load_basic_set();
        start_pass(8'd0, 8'd0);
        strobes = 0;
        stray   = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (ready_a) strobes++;
        end
        rst = 1'b1;                     // driven at the negedge after strobe 2
        for (int c = 2; c < 9; c++) begin
            @(negedge clk);
            if (c == 2) begin
                n_cmp++;
                if (data_a !== 32'd0 || idx_a !== 4'd0) begin
                    n_bad++;
                    $display("FAIL midreset_outputs: got DATA_OUT=%0d IDX_OUT=%0d required 0/0", data_a, idx_a);
                end
            end
            if (ready_a || done_a || busy_a) stray++;
            if (c == 4) rst = 1'b0;
        end
        n_cmp++;
        if (strobes !== 2) begin
            n_bad++;
            $display("FAIL midreset_prefix: got %0d strobes before reset required 2", strobes);
        end
        n_cmp++;
        if (stray !== 0) begin
            n_bad++;
            $display("FAIL midreset_quiet: got %0d cycles with ready/done/busy required 0", stray);
        end
        @(posedge clk);
        #1;
        start_pass(8'd0, 8'd0);
        collect(1'b0, 5);
        n_cmp++;
        if (obs_idx.size() != 0 || obs_done_cyc !== 0 || obs_busy_cnt !== 0) begin
            n_bad++;
            $display("FAIL midreset_restart: got strobes=%0d done_cyc=%0d busy=%0d required 0/0/0",
                     obs_idx.size(), obs_done_cyc, obs_busy_cnt);
        end
    endtask

    task automatic test_ignored_inputs();
        do_reset();
        load_basic_set();
        for (int pass = 0; pass < 2; pass++) begin
            int k;
            push_basic_expect(1);
            start_pass(8'd0, 8'd0);
            if (pass == 0) begin
                fork
                    collect(1'b0, 10);
                    begin
                        @(posedge clk);
                        @(posedge clk);
                        #1;
                        start = 1'b1; load = 1'b1; clear = 1'b1;
                        load_x = 8'd7; load_y = 8'd7;
                        test_x = 8'd200; test_y = 8'd9;
                        @(posedge clk);
                        @(posedge clk);
                        #1 start = 1'b0; load = 1'b0; clear = 1'b0;
                    end
                join
            end else begin
                collect(1'b0, 10);   // buffer must have survived the first pass
            end
            n_cmp++;
            if (obs_idx.size() != 4 || obs_done_cnt !== 1) begin
                n_bad++;
                $display("FAIL ignored_p%0d_count: got strobes=%0d done_cnt=%0d required 4/1",
                         pass, obs_idx.size(), obs_done_cnt);
            end
            k = 0;
            while (exp_idx.size() > 0 && obs_idx.size() > 0) begin
                int ei, ed, ec, oi, od, oc;
                ei = exp_idx.pop_front(); ed = exp_dist.pop_front(); ec = exp_cyc.pop_front();
                oi = obs_idx.pop_front(); od = obs_dist.pop_front(); oc = obs_cyc.pop_front();
                n_cmp++;
                if (oi !== ei || od !== ed || oc !== ec) begin
                    n_bad++;
                    $display("FAIL ignored_p%0d_strobe%0d: got idx=%0d dist=%0d cyc=%0d required idx=%0d dist=%0d cyc=%0d",
                             pass, k, oi, od, oc, ei, ed, ec);
                end
                k++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; clear = 1'b0; start = 1'b0;
        load_x = '0; load_y = '0; test_x = '0; test_y = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_gap();
        test_empty_and_clear();
        test_overflow();
        test_reset_mid_pass();
        test_ignored_inputs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
